// File: rtl/scan_seq_pkg.sv
// Shared types and slot-ordering helper for the scan select sequencer.
package scan_seq_pkg;

    localparam int unsigned SEL_W     = 3;
    localparam int unsigned MAX_SLOTS = 1 << SEL_W;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DWELL
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] slot;
    } slot_sel_t;

    // First unmasked slot after cur (or from slot 0 when from_first), wrapping to the lowest unmasked slot.
    function automatic slot_sel_t next_slot(
        input logic [SEL_W-1:0]     cur,
        input logic                 from_first,
        input logic [MAX_SLOTS-1:0] mask,
        input int unsigned          num_slots
    );
        slot_sel_t r;
        r = '0;
        for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
            if (!r.valid && i < num_slots && !mask[i[SEL_W-1:0]] && (from_first || i > 32'(cur))) begin
                r.valid = 1'b1;
                r.slot  = i[SEL_W-1:0];
            end
        end
        for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
            if (!r.valid && i < num_slots && !mask[i[SEL_W-1:0]]) begin
                r.valid = 1'b1;
                r.slot  = i[SEL_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; expire is high while the count equals 1, and the count never wraps below 0.
module scan_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == W'(1));

endmodule

// File: rtl/scan_select_sequencer.sv
// Steps the 3-to-8 decoder select {A,B,C} through scan slots with blanked, glitch-free enable pulses.
// Optional SCAN_SKIP_MASK_EN adds skip_mask[7:0] to drop individual slots from the frame.
module scan_select_sequencer
    import scan_seq_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned NUM_SLOTS    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       single,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [7:0] skip_mask,
`endif
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       en,
    output logic       slot_strobe,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    state_e               state_q, state_d;
    logic [SEL_W-1:0]     slot_q, slot_d;
    logic                 stop_pending_q, stop_pending_d;
    logic                 last_q, last_d;
    logic                 en_q, en_d;
    logic                 slot_strobe_q, slot_strobe_d;
    logic                 busy_q, busy_d;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_value;
    logic                 tmr_expire;
    logic [MAX_SLOTS-1:0] mask;
    slot_sel_t            first_sel, next_sel, after_sel;

`ifdef SCAN_SKIP_MASK_EN
    assign mask = skip_mask;
`else
    assign mask = '0;
`endif

    scan_timer #(
        .W (TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .value  (tmr_value),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            slot_q         <= '0;
            stop_pending_q <= 1'b0;
            last_q         <= 1'b0;
            en_q           <= 1'b0;
            slot_strobe_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            slot_q         <= slot_d;
            stop_pending_q <= stop_pending_d;
            last_q         <= last_d;
            en_q           <= en_d;
            slot_strobe_q  <= slot_strobe_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        first_sel      = next_slot('0, 1'b1, mask, NUM_SLOTS);
        next_sel       = next_slot(slot_q, 1'b0, mask, NUM_SLOTS);
        state_d        = state_q;
        slot_d         = slot_q;
        stop_pending_d = stop_pending_q;
        tmr_load       = 1'b0;
        tmr_value      = TW'(BLANK_CYCLES);
        case (state_q)
            IDLE: begin
                if (start && first_sel.valid) begin
                    state_d        = BLANK;
                    slot_d         = first_sel.slot;
                    stop_pending_d = stop;
                    tmr_load       = 1'b1;
                end
            end
            BLANK: begin
                stop_pending_d = stop_pending_q | stop;
                if (tmr_expire) begin
                    state_d   = DWELL;
                    tmr_load  = 1'b1;
                    tmr_value = TW'(DWELL_CYCLES);
                end
            end
            DWELL: begin
                stop_pending_d = stop_pending_q | stop;
                if (tmr_expire) begin
                    // last_q is the frame-end decision; an empty mask also ends the frame here.
                    if (last_q) begin
                        if (single || stop_pending_q || stop || !first_sel.valid) begin
                            state_d        = IDLE;
                            stop_pending_d = 1'b0;
                        end else begin
                            state_d  = BLANK;
                            slot_d   = first_sel.slot;
                            tmr_load = 1'b1;
                        end
                    end else if (next_sel.valid) begin
                        state_d  = BLANK;
                        slot_d   = next_sel.slot;
                        tmr_load = 1'b1;
                    end else begin
                        state_d        = IDLE;
                        stop_pending_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        after_sel     = next_slot(slot_d, 1'b0, mask, NUM_SLOTS);
        last_d        = !after_sel.valid || (after_sel.slot <= slot_d);
        en_d          = (state_d == DWELL);
        slot_strobe_d = (state_d == DWELL) && (state_q != DWELL);
        busy_d        = (state_d != IDLE);
    end

    assign {A, B, C}   = slot_q;
    assign en          = en_q;
    assign slot_strobe = slot_strobe_q;
    assign busy        = busy_q;
    // Decode of flops only: last dwell cycle of the frame's final slot.
    assign frame_done  = en_q & tmr_expire & last_q;

endmodule

// File: tb/tb_scan_select_sequencer.sv
// Directed self-checking bench for scan_select_sequencer (DWELL=4, BLANK=2; 8-slot and 5-slot instances).
module tb_scan_select_sequencer;

    logic clk = 1'b0;
    logic rst, start, stop, single;
    logic A, B, C, en, slot_strobe, frame_done, busy;
    logic start5, stop5, single5;
    logic A5, B5, C5, en5, slot_strobe5, frame_done5, busy5;
    logic [2:0] abc, abc5;
`ifdef SCAN_SKIP_MASK_EN
    logic [7:0] skip_mask, skip_mask5;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int fd_q[$];
    logic [2:0] sq[$];
    int glitch, en_cnt;
    logic [2:0] p_abc;
    logic p_en;

    always #5 clk = ~clk;

    assign abc  = {A, B, C};
    assign abc5 = {A5, B5, C5};

    scan_select_sequencer #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2),
        .NUM_SLOTS    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .single      (single),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask   (skip_mask),
`endif
        .A           (A),
        .B           (B),
        .C           (C),
        .en          (en),
        .slot_strobe (slot_strobe),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    scan_select_sequencer #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2),
        .NUM_SLOTS    (5)
    ) dut5 (
        .clk         (clk),
        .rst         (rst),
        .start       (start5),
        .stop        (stop5),
        .single      (single5),
`ifdef SCAN_SKIP_MASK_EN
        .skip_mask   (skip_mask5),
`endif
        .A           (A5),
        .B           (B5),
        .C           (C5),
        .en          (en5),
        .slot_strobe (slot_strobe5),
        .frame_done  (frame_done5),
        .busy        (busy5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc    = -1;
        fd_q.delete();
        sq.delete();
        glitch = 0;
        en_cnt = 0;
        p_abc  = abc;
        p_en   = en;
    endtask

    // One cycle, sampled at the falling edge; also watches select/enable ordering.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (slot_strobe) sq.push_back(abc);
        if (frame_done) fd_q.push_back(cyc);
        if (en) en_cnt++;
        if (en && abc != p_abc) glitch++;
        if (p_en && en && abc != p_abc) glitch++;
        p_abc = abc;
        p_en  = en;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic pulse_start(input logic with_stop);
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    function automatic int fd_at(input int idx);
        return (fd_q.size() > idx) ? fd_q[idx] : -1;
    endfunction

    function automatic int sq_at(input int idx);
        return (sq.size() > idx) ? int'(sq[idx]) : -1;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0;
        start5 = 1'b0; stop5 = 1'b0; single5 = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
        skip_mask = 8'h00; skip_mask5 = 8'h00;
`endif
        repeat (2) @(negedge clk);
        check("rst_en", en, 0);
        check("rst_abc", abc, 0);
        check("rst_busy", busy, 0);
        check("rst_strobe", slot_strobe, 0);
        check("rst_fd", frame_done, 0);
        rst = 1'b0;
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        check("idle_stop_ignored", busy, 0);

        // First frame timing
        clear_stats();
        pulse_start(1'b0);
        check("t1_abc0", abc, 0);
        check("t1_blank_en0", en, 0);
        check("t1_busy", busy, 1);
        tick();
        check("t1_blank_en1", en, 0);
        tick();
        check("t1_dwell_en", en, 1);
        check("t1_strobe", slot_strobe, 1);
        tick();
        check("t1_strobe_once", slot_strobe, 0);
        run_to(6);
        check("t1_en_fall", en, 0);
        check("t1_abc1", abc, 1);
        run_to(48);
        check("t1_fd_count", fd_q.size(), 1);
        check("t1_fd_cycle", fd_at(0), 47);
        check("t1_strobes", sq.size(), 8);
        check("t1_last_slot", sq_at(7), 7);

        // Free run, three frames
        run_to(150);
        check("t2_fd_count", fd_q.size(), 3);
        check("t2_fd_third", fd_at(2), 143);
        check("t2_strobes", sq.size(), 25);
        check("t2_wrap", sq_at(8), 0);
        check("t2_slot7", sq_at(15), 7);
        check("t2_wrap2", sq_at(24), 0);
        check("t2_en_cycles", en_cnt, 100);
        check("t2_glitch", glitch, 0);

        // single halts at the end of the running frame, then a single-frame run
        single = 1'b1;
        run_to(191);
        check("t3_fd", frame_done, 1);
        tick();
        check("t3_busy_off", busy, 0);
        check("t3_abc_hold", abc, 7);
        check("t3_en_off", en, 0);
        clear_stats();
        pulse_start(1'b0);
        run_to(48);
        check("t3b_fd_cycle", fd_at(0), 47);
        check("t3b_busy", busy, 0);
        check("t3b_abc", abc, 7);
        single = 1'b0;

        // stop during slot 3 finishes the frame with full dwells
        clear_stats();
        pulse_start(1'b0);
        run_to(20);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_to(48);
        check("t4_busy", busy, 0);
        check("t4_fd_count", fd_q.size(), 1);
        check("t4_strobes", sq.size(), 8);
        check("t4_en_cycles", en_cnt, 32);
        run_to(55);
        check("t4_stays_idle", busy, 0);
        clear_stats();
        pulse_start(1'b1);
        check("t4_restart_abc", abc, 0);
        check("t4_restart_busy", busy, 1);
        run_to(48);
        check("t4_startstop_idle", busy, 0);
        check("t4_startstop_fd", fd_q.size(), 1);

        // async reset mid-dwell
        clear_stats();
        pulse_start(1'b0);
        run_to(21);
        check("t5_pre_en", en, 1);
        check("t5_pre_abc", abc, 3);
        #2 rst = 1'b1;
        #1;
        check("t5_async_en", en, 0);
        check("t5_async_abc", abc, 0);
        check("t5_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_needs_start", busy, 0);

        // five-slot instance wraps 100 -> 000
        clear_stats();
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        run_to(26);
        check("t5n_abc4", abc5, 4);
        check("t5n_en4", en5, 1);
        run_to(29);
        check("t5n_fd", frame_done5, 1);
        run_to(30);
        check("t5n_wrap_abc", abc5, 0);
        check("t5n_wrap_en", en5, 0);
        run_to(32);
        check("t5n_wrap_strobe", slot_strobe5, 1);
        stop5 = 1'b1;
        tick();
        stop5 = 1'b0;
        run_to(70);
        check("t5n_stopped", busy5, 0);

`ifdef SCAN_SKIP_MASK_EN
        skip_mask = 8'hAA;
        single    = 1'b1;
        clear_stats();
        pulse_start(1'b0);
        run_to(24);
        check("t6_fd_cycle", fd_at(0), 23);
        check("t6_strobes", sq.size(), 4);
        check("t6_slot2", sq_at(1), 2);
        check("t6_slot6", sq_at(3), 6);
        check("t6_idle", busy, 0);
        skip_mask = 8'hFF;
        pulse_start(1'b0);
        check("t6_all_masked", busy, 0);
        tick();
        check("t6_all_masked2", busy, 0);
        skip_mask = 8'h00;
        single    = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
